// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Job-level controller in front of one DSP MAC slice. It takes a dot-product
//   command, streams operand pairs into the slice, waits out the slice output
//   latency and returns the 2*WIDTH result over a valid/ready port.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-low reset
//   cmd_*                  command handshake: len, mode, pipe depth, bias
//   op_*                   operand pair handshake (A, B)
//   dsp_*                  slice controls/operands out, dsp_out result in
//   res_*                  result handshake
//   err                    one-cycle pulse when a command with mode 11 is dropped
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// RUN    | start/mac high, forwarding operand beats until len are accepted
// DRAIN  | slice idle, counting down the configured output latency
// DONE   | result held on res_data with res_valid high until res_ready
module dsp_mac_sequencer #(
  parameter int WIDTH         = 16,
  parameter int PIPELINE_BITS = 3,
  parameter int LEN_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_BITS-1:0]      cmd_len,
  input  logic [1:0]               cmd_mode,
  input  logic [PIPELINE_BITS-1:0] cmd_pipe,
  input  logic [2*WIDTH-1:0]       cmd_bias,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     dsp_start,
  output logic                     dsp_mac,
  output logic [1:0]               dsp_mode,
  output logic [WIDTH-1:0]         dsp_aa,
  output logic [WIDTH-1:0]         dsp_bb,
  output logic [2*WIDTH-1:0]       dsp_cc,
  output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
  output logic                     dsp_shift_enable,
  input  logic [2*WIDTH-1:0]       dsp_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_data,
  output logic                     err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [LEN_BITS-1:0]      r_len;
  logic [LEN_BITS-1:0]      r_cnt;
  logic [PIPELINE_BITS-1:0] r_drain;
  logic [1:0]               r_mode;
  logic [PIPELINE_BITS-1:0] r_pipe;
  logic [2*WIDTH-1:0]       r_bias;
  logic [2*WIDTH-1:0]       r_res;
  logic                     r_cmd_ready;
  logic                     r_run;
  logic                     r_res_valid;
  logic                     r_err;

  logic w_op_ready;
  logic w_op_fire;
  logic w_last;

  // r_run is high exactly while in RUN; it is set/cleared on the transitions.
  assign w_op_ready = r_run && (r_cnt < r_len);
  assign w_op_fire  = w_op_ready && op_valid;
  assign w_last     = w_op_fire && (LEN_BITS'(r_cnt + 1'b1) == r_len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_mode      <= '0;
      r_pipe      <= '0;
      r_bias      <= '0;
      r_res       <= '0;
      r_cmd_ready <= 1'b1;
      r_run       <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_mode == 2'b11) begin
              // illegal mode: nothing is latched, the slice keeps its old setup
              r_err <= 1'b1;
            end else begin
              r_len       <= cmd_len;
              r_mode      <= cmd_mode;
              r_pipe      <= cmd_pipe;
              r_bias      <= cmd_bias;
              r_cnt       <= '0;
              r_cmd_ready <= 1'b0;
              if (cmd_len == '0) begin
                // empty dot product: the answer is just the bias
                r_res       <= cmd_bias;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_run   <= 1'b1;
                r_state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (w_op_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_run <= 1'b0;
              if (r_pipe == '0) begin
                // zero-latency slice: result already includes this beat
                r_res       <= dsp_out;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_drain <= r_pipe - 1'b1;
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_res       <= dsp_out;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign op_ready         = w_op_ready;
  assign dsp_start        = r_run;
  assign dsp_mac          = r_run;
  assign dsp_mode         = r_mode;
  // bubbles feed zeros so the slice adds nothing while holding its accumulator
  assign dsp_aa           = w_op_fire ? op_a : '0;
  assign dsp_bb           = w_op_fire ? op_b : '0;
  assign dsp_cc           = r_bias;
  assign dsp_pipe_stages  = r_pipe;
  assign dsp_shift_enable = 1'b0;
  assign res_valid        = r_res_valid;
  assign res_data         = r_res;
  assign err              = r_err;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;
  localparam int W  = 16;
  localparam int PB = 3;
  localparam int LB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LB-1:0] cmd_len = '0;
  logic [1:0]    cmd_mode = '0;
  logic [PB-1:0] cmd_pipe = '0;
  logic [2*W-1:0] cmd_bias = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          dsp_start, dsp_mac, dsp_shift_enable;
  logic [1:0]    dsp_mode;
  logic [W-1:0]  dsp_aa, dsp_bb;
  logic [2*W-1:0] dsp_cc;
  logic [PB-1:0] dsp_pipe_stages;
  logic [2*W-1:0] dsp_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [2*W-1:0] res_data;
  logic          err;

  int checks = 0;
  int errors = 0;

  dsp_mac_sequencer #(.WIDTH(W), .PIPELINE_BITS(PB), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_mode(cmd_mode), .cmd_pipe(cmd_pipe), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_mode(dsp_mode),
    .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
    .dsp_pipe_stages(dsp_pipe_stages), .dsp_shift_enable(dsp_shift_enable),
    .dsp_out(dsp_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Behavioural MAC slice: accumulates onto its own result when the previous
  // cycle had mac=1, otherwise starts from cc; output delayed by pipe_stages.
  logic [31:0] m_acc, m_sum, m_pa, m_pb;
  logic        m_mac_q;
  logic [31:0] m_hist [0:7];

  always_comb begin
    m_pa    = {{16{dsp_aa[15]}}, dsp_aa};
    m_pb    = {{16{dsp_bb[15]}}, dsp_bb};
    m_sum   = (m_mac_q ? m_acc : dsp_cc) + m_pa * m_pb;
    dsp_out = (dsp_pipe_stages == '0) ? m_sum : m_hist[dsp_pipe_stages];
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_acc   <= '0;
      m_mac_q <= 1'b0;
      for (int k = 0; k < 8; k++) m_hist[k] <= '0;
    end else begin
      if (dsp_start) m_acc <= m_sum;
      m_mac_q   <= dsp_mac;
      m_hist[0] <= '0;
      m_hist[1] <= m_sum;
      for (int k = 2; k < 8; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  int start_cnt = 0;
  int err_cnt   = 0;
  always @(posedge clk) begin
    if (dsp_start) start_cnt++;
    if (err) err_cnt++;
  end

  logic [15:0] ja [0:255];
  logic [15:0] jb [0:255];

  // Reference: bias + sum of signed products, wrapping at 32 bits.
  function automatic logic [31:0] ref_dot(input int len, input logic [31:0] bias);
    logic [31:0] acc, sa, sb;
    acc = bias;
    for (int i = 0; i < len; i++) begin
      sa  = {{16{ja[i][15]}}, ja[i]};
      sb  = {{16{jb[i][15]}}, jb[i]};
      acc = acc + sa * sb;
    end
    return acc;
  endfunction

  // Drives one full job; reports what it saw. Called at a negedge.
  task automatic run_job(input int len, input int mode, input int pipe,
                         input logic [31:0] bias, input int bub_pct,
                         input int bub_before, input int bub_n, input int rdy_delay,
                         output logic [31:0] res, output int lat, output int nbub,
                         output int bub_bad, output int stall_bad, output int leak_bad,
                         output bit tmo);
    int beat, cycles, inserted;
    beat = 0; cycles = 0; inserted = 0;
    nbub = 0; bub_bad = 0; stall_bad = 0; leak_bad = 0; tmo = 0; res = '0;
    cmd_valid = 1'b1;
    cmd_len   = LB'(len);
    cmd_mode  = 2'(mode);
    cmd_pipe  = PB'(pipe);
    cmd_bias  = bias;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (beat < len && cycles < 1000) begin
      if ((beat == bub_before && inserted < bub_n) || ($urandom_range(99) < bub_pct)) begin
        if (beat == bub_before) inserted++;
        op_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
      end else begin
        op_valid = 1'b1;
        op_a = ja[beat];
        op_b = jb[beat];
      end
      #1;
      if (!op_valid) begin
        nbub++;
        if (dsp_start !== 1'b1 || dsp_mac !== 1'b1 || dsp_aa !== '0 || dsp_bb !== '0 || op_ready !== 1'b1)
          bub_bad++;
      end else if (op_ready === 1'b1) begin
        if (dsp_aa !== ja[beat] || dsp_bb !== jb[beat]) bub_bad++;
        beat++;
      end
      @(negedge clk);
      cycles++;
    end
    if (beat < len) tmo = 1;
    lat = 1;
    while (!res_valid && lat < 64) begin
      op_valid = 1'b1;
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      #1;
      if (op_ready !== 1'b0 || dsp_aa !== '0 || dsp_bb !== '0 || dsp_start !== 1'b0) leak_bad++;
      @(negedge clk);
      lat++;
    end
    op_valid = 1'b0;
    if (!res_valid) tmo = 1;
    res = res_data;
    for (int i = 0; i < rdy_delay; i++) begin
      if (res_data !== res || res_valid !== 1'b1 || cmd_ready !== 1'b0 || dsp_mac !== 1'b0)
        stall_bad++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, op_ready, dsp_start, dsp_mac, res_valid, err, dsp_shift_enable} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=1000000", {cmd_ready, op_ready, dsp_start, dsp_mac, res_valid, err, dsp_shift_enable});
    end
    checks++;
    if ({dsp_mode, dsp_cc, dsp_pipe_stages, res_data, dsp_aa, dsp_bb} !== '0) begin
      errors++;
      $display("FAIL reset_data mode=%0d cc=%0h pipe=%0d res=%0h aa=%0h bb=%0h exp all 0",
               dsp_mode, dsp_cc, dsp_pipe_stages, res_data, dsp_aa, dsp_bb);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_basic;
    ja[0] = 16'd2;  jb[0] = 16'd3;
    ja[1] = -16'sd4; jb[1] = 16'd5;
    ja[2] = 16'd7;  jb[2] = 16'd7;
  endtask

  task automatic test_basic;
    logic [31:0] res; int lat, nbub, bb_bad, st_bad, lk_bad; bit tmo;
    load_basic();
    run_job(3, 2, 2, 32'd100, 0, 99, 0, 0, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (tmo || res !== 32'd135) begin
      errors++; $display("FAIL basic_res got=%0d tmo=%0d exp=135", res, tmo);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++;
    if (bb_bad !== 0 || lk_bad !== 0) begin
      errors++; $display("FAIL basic_passthru got=%0d/%0d exp=0/0", bb_bad, lk_bad);
    end
    checks++;
    if ({dsp_mode, dsp_pipe_stages, dsp_cc} !== {2'd2, 3'd2, 32'd100}) begin
      errors++; $display("FAIL basic_latched got mode=%0d pipe=%0d cc=%0d exp 2/2/100", dsp_mode, dsp_pipe_stages, dsp_cc);
    end
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got valid=%0b ready=%0b exp 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_bubbles;
    logic [31:0] res; int lat, nbub, bb_bad, st_bad, lk_bad; bit tmo;
    load_basic();
    run_job(3, 2, 2, 32'd100, 0, 2, 2, 0, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (nbub !== 2 || bb_bad !== 0) begin
      errors++; $display("FAIL bubble_ctrl got bubbles=%0d bad=%0d exp 2/0", nbub, bb_bad);
    end
    checks++;
    if (tmo || res !== 32'd135 || lat !== 3) begin
      errors++; $display("FAIL bubble_res got=%0d lat=%0d exp=135 lat=3", res, lat);
    end
  endtask

  task automatic test_zero_len;
    logic [31:0] res; int lat, nbub, bb_bad, st_bad, lk_bad, s0; bit tmo;
    s0 = start_cnt;
    run_job(0, 1, 3, -32'sd5, 0, 99, 0, 0, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (tmo || res !== 32'hFFFF_FFFB || lat > 2) begin
      errors++; $display("FAIL zero_len_res got=%0h lat=%0d exp=fffffffb lat<=2", res, lat);
    end
    checks++;
    if (start_cnt !== s0) begin
      errors++; $display("FAIL zero_len_start got=%0d exp=%0d", start_cnt, s0);
    end
  endtask

  task automatic test_illegal;
    int s0, e0;
    s0 = start_cnt; e0 = err_cnt;
    cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_len = 8'd5; cmd_pipe = 3'd1; cmd_bias = 32'd9;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mode = 2'b00;
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || op_ready !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse got err=%0b ready=%0b op_ready=%0b exp 1/1/0", err, cmd_ready, op_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_clear got err=%0b ready=%0b exp 0/1", err, cmd_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt !== s0 || err_cnt !== e0 + 1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_idle got starts=%0d errs=%0d valid=%0b exp %0d/%0d/0", start_cnt - s0, err_cnt - e0, res_valid, 0, 1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; int lat, nbub, bb_bad, st_bad, lk_bad; bit tmo;
    load_basic();
    run_job(3, 2, 2, 32'd100, 0, 99, 0, 5, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (tmo || res !== 32'd135 || st_bad !== 0) begin
      errors++; $display("FAIL bp_hold got=%0d stall_bad=%0d exp=135/0", res, st_bad);
    end
    checks++;
    if (dsp_mac !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got mac=%0b ready=%0b exp 0/1", dsp_mac, cmd_ready);
    end
    ja[0] = 16'd3; jb[0] = 16'd3;
    ja[1] = 16'd1; jb[1] = -16'sd2;
    run_job(2, 0, 0, 32'd0, 0, 99, 0, 0, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (tmo || res !== 32'd7 || lat !== 1) begin
      errors++; $display("FAIL b2b_res got=%0d lat=%0d exp=7 lat=1", res, lat);
    end
  endtask

  task automatic test_reset_mid_job;
    logic [31:0] res, exp; int lat, nbub, bb_bad, st_bad, lk_bad, seen; bit tmo;
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_mode = 2'd2; cmd_pipe = 3'd3; cmd_bias = 32'd77;
    @(negedge clk);
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 16'd5; op_b = 16'd6;
    repeat (2) @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, op_ready, dsp_start, dsp_mac, res_valid, err} !== 6'b100000 ||
        {dsp_mode, dsp_cc, dsp_pipe_stages, res_data} !== '0) begin
      errors++; $display("FAIL midrst_outputs got ctrl=%b cc=%0h mode=%0d pipe=%0d exp ctrl=100000 zeros",
                         {cmd_ready, op_ready, dsp_start, dsp_mac, res_valid, err}, dsp_cc, dsp_mode, dsp_pipe_stages);
    end
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || dsp_start !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_abandon got=%0d active cycles exp=0", seen); end
    for (int i = 0; i < 4; i++) begin ja[i] = 16'($urandom); jb[i] = 16'($urandom); end
    exp = ref_dot(4, 32'hDEAD_0001);
    run_job(4, 1, 1, 32'hDEAD_0001, 20, 99, 0, 1, res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
    checks++;
    if (tmo || res !== exp || lat !== 2) begin
      errors++; $display("FAIL midrst_fresh got=%0h lat=%0d exp=%0h lat=2", res, lat, exp);
    end
  endtask

  task automatic test_random;
    logic [31:0] res, exp, bias; int lat, nbub, bb_bad, st_bad, lk_bad, len, mode, pipe, elat, s0; bit tmo;
    for (int j = 0; j < 25; j++) begin
      len  = $urandom_range(12);
      mode = $urandom_range(2);
      pipe = $urandom_range(7);
      bias = $urandom;
      for (int i = 0; i < len; i++) begin ja[i] = 16'($urandom); jb[i] = 16'($urandom); end
      exp  = ref_dot(len, bias);
      elat = (len == 0) ? 1 : pipe + 1;
      s0   = start_cnt;
      run_job(len, mode, pipe, bias, 30, 99, 0, $urandom_range(3), res, lat, nbub, bb_bad, st_bad, lk_bad, tmo);
      checks++;
      if (tmo || res !== exp) begin
        errors++; $display("FAIL rand_res job=%0d len=%0d pipe=%0d got=%0h exp=%0h", j, len, pipe, res, exp);
      end
      checks++;
      if (lat !== elat || start_cnt - s0 !== len + nbub) begin
        errors++; $display("FAIL rand_timing job=%0d got lat=%0d starts=%0d exp lat=%0d starts=%0d",
                           j, lat, start_cnt - s0, elat, len + nbub);
      end
      checks++;
      if (bb_bad !== 0 || st_bad !== 0 || lk_bad !== 0) begin
        errors++; $display("FAIL rand_handshake job=%0d got bad=%0d/%0d/%0d exp 0/0/0", j, bb_bad, st_bad, lk_bad);
      end
      checks++;
      if (len != 0 && {dsp_mode, dsp_pipe_stages, dsp_cc} !== {2'(mode), 3'(pipe), bias}) begin
        errors++; $display("FAIL rand_latched job=%0d got mode=%0d pipe=%0d cc=%0h exp %0d/%0d/%0h",
                           j, dsp_mode, dsp_pipe_stages, dsp_cc, mode, pipe, bias);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_illegal();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Job-level controller in front of one DSP MAC slice.
- Accepts a dot-product command (length, mode, pipeline depth, bias) and streams operand pairs into the slice with valid/ready.
- Drives the slice's start/mac/cc controls so the slice accumulates correctly, waits out the configured pipeline latency, then returns the 2*WIDTH result over a valid/ready port.

Parameters:
WIDTH, 16, operand width; result and bias are 2*WIDTH.
PIPELINE_BITS, 3, width of the slice pipe_stages field.
LEN_BITS, 8, width of the job length field (max 2^LEN_BITS-1 beats).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
cmd_len  in  LEN_BITS  number of operand beats.
cmd_mode  in  2  slice mode: 00, 01 or 10; 11 is illegal.
cmd_pipe  in  PIPELINE_BITS  slice output latency in cycles.
cmd_bias  in  2*WIDTH  signed initial accumulator value.
op_valid  in  1  operand pair offered.
op_ready  out  1  operand pair accepted this cycle.
op_a  in  WIDTH  operand A.
op_b  in  WIDTH  operand B.
dsp_start  out  1  slice start.
dsp_mac  out  1  slice mac.
dsp_mode  out  2  slice mode (latched cmd_mode).
dsp_aa  out  WIDTH  slice A operand.
dsp_bb  out  WIDTH  slice B operand.
dsp_cc  out  2*WIDTH  slice addend (latched cmd_bias).
dsp_pipe_stages  out  PIPELINE_BITS  latched cmd_pipe.
dsp_shift_enable  out  1  constant 0.
dsp_out  in  2*WIDTH  slice result.
res_valid  out  1  result available.
res_ready  in  1  result consumed.
res_data  out  2*WIDTH  signed result.
err  out  1  one-cycle pulse when an illegal command is dropped.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Counters and latched fields cleared.
  - Reset mid-job abandons the job; no result is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch len/mode/pipe/bias.
  - mode=11: drop the command, err=1 next cycle, stay IDLE.
  - len=0: res_data<=bias, go to DONE; the slice is never started.
  - Otherwise beat counter<=0, go to RUN.
- RUN:
  - dsp_start=1 and dsp_mac=1 every cycle.
  - op_ready=1 while the beat counter < len.
  - op_valid&&op_ready: dsp_aa=op_a, dsp_bb=op_b (combinational pass-through); counter increments.
  - op_valid low: bubble beat with dsp_aa=dsp_bb=0, start and mac still 1. This preserves the accumulator in every mode and adds 0.
  - The first RUN cycle follows an IDLE cycle with dsp_mac=0, so the slice adds dsp_cc (bias) on beat 0 and accumulates on every later beat.
  - On the cycle the final beat is accepted (cycle t_last):
    - cmd_pipe=0: res_data<=dsp_out that cycle, go to DONE.
    - Else go to DRAIN with drain counter<=cmd_pipe-1.
- DRAIN:
  - dsp_start=0, dsp_mac=0, op_ready=0.
  - Decrement the drain counter.
  - At 0 (cycle t_last+cmd_pipe): res_data<=dsp_out, go to DONE.
- DONE:
  - res_valid=1, with res_data held stable until res_ready.
  - On res_valid&&res_ready: go to IDLE, res_valid<=0 next cycle.
- Back-to-back jobs:
  - There is always at least one cycle with dsp_mac=0 between jobs (DRAIN/DONE/IDLE), so a new job never chains onto the previous accumulator.
- Arithmetic:
  - All accumulation is done inside the slice.
  - The sequencer never modifies dsp_out.
  - Overflow wraps at 2*WIDTH, two's complement.
- dsp_mode, dsp_cc and dsp_pipe_stages hold their latched values from command accept until the next accept. They are 0 after reset.
- Operand handshake outside RUN: op_ready=0, and operands offered then are neither consumed nor forwarded.

Test Plan:
- Basic job: mode=10, len=3, pipe=2, bias=100, pairs (2,3),(-4,5),(7,7) back-to-back -> res_data=135. res_valid rises exactly 3 cycles after t_last (capture at t_last+2, valid one cycle later).
- Bubbles: same job with op_valid low for 2 cycles between beats 1 and 2 -> dsp_start stays 1 with aa=bb=0 during the bubbles; res_data=135.
- Zero-length: len=0, bias=-5 -> dsp_start never asserts; res_valid within 2 cycles of accept with res_data=-5.
- Illegal mode: cmd_mode=11 -> err pulses high for 1 cycle; state stays IDLE; cmd_ready stays 1; no dsp_start.
- Backpressure and back-to-back: res_ready low for 5 cycles -> res_data stable and cmd_ready=0 throughout. Second job mode=00, len=2, pipe=0, bias=0, pairs (3,3),(1,-2) -> res_data=7, with dsp_mac=0 for at least 1 cycle between jobs.
- Reset mid-job: rst=0 during RUN of a len=4 job -> next cycle all outputs 0 and cmd_ready=1; no res_valid; a following fresh job returns a correct result.
